multi_mode_load_counter: RTL and testbench
==========================================

MULTI_MODE_LOAD_COUNTER -- requirements
Module: multi_mode_load_counter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named Clk and Rst.
REQ-002 Parameter WIDTH, default 4, SHALL set the bit width of Count and Load_Value.
REQ-003 Parameter MAX_VALUE, default 2**WIDTH-1, SHALL set the upper count limit; legal range is 1..2**WIDTH-1.
REQ-004 Port Clk, input, 1, SHALL be the rising-edge clock.
REQ-005 Port Rst, input, 1, SHALL be the synchronous active-high reset.
REQ-006 Port Enable, input, 1, SHALL permit a count step when high.
REQ-007 Port Up_Down, input, 1, SHALL select direction: 1 = up, 0 = down.
REQ-008 Port Mode, input, 1, SHALL select limit behaviour: 0 = wrap, 1 = saturate.
REQ-009 Port Clear, input, 1, SHALL request a synchronous clear to 0.
REQ-010 Port Load_Value_Valid, input, 1, SHALL qualify Load_Value.
REQ-011 Port Load_Value, input, WIDTH, SHALL be the value to load.
REQ-012 Port Count, output, WIDTH, SHALL be the registered counter value.
REQ-013 Port Terminal_Count, output, 1, SHALL be a combinational limit indicator.
REQ-014 Port Wrap, output, 1, SHALL be a registered one-cycle wrap pulse.
REQ-015 Port Sat, output, 1, SHALL be a registered saturation-hold flag.
REQ-016 Port Load_Error, output, 1, SHALL be a registered one-cycle out-of-range-load pulse.

Function
REQ-017 Per-edge priority SHALL be Rst > Clear > Load_Value_Valid > Enable > hold.
REQ-018 Clear SHALL set Count=0 on the next edge, ignoring Load_Value_Valid and Enable.
REQ-019 A load SHALL set Count=Load_Value on the next edge if Load_Value<=MAX_VALUE; no count step occurs that cycle.
REQ-020 A load with Load_Value>MAX_VALUE SHALL set Count=MAX_VALUE and Load_Error=1 for exactly that following cycle.
REQ-021 Enable=1, up, Count<MAX_VALUE: Count SHALL become Count+1.
REQ-022 Enable=1, down, Count>0: Count SHALL become Count-1.
REQ-023 Enable=1, up, Count==MAX_VALUE, Mode=0: Count SHALL become 0, with Wrap=1 in the same cycle Count shows 0.
REQ-024 Enable=1, down, Count==0, Mode=0: Count SHALL become MAX_VALUE, with Wrap=1 in the same cycle Count shows MAX_VALUE.
REQ-025 Enable=1 at the limit with Mode=1: Count SHALL hold, and Sat=1 on the next edge; Sat remains 1 while each subsequent edge is a blocked step.
REQ-026 Wrap, Sat and Load_Error SHALL be 0 after any edge that is not the qualifying event, including hold, Clear and load.
REQ-027 Terminal_Count SHALL equal (Up_Down && Count==MAX_VALUE) || (!Up_Down && Count==0), independent of Enable and Mode.
REQ-028 Changing Up_Down or Mode mid-count SHALL take effect on the next edge with no extra latency.
REQ-029 Count SHALL never exceed MAX_VALUE in any reachable state.
REQ-030 All arithmetic SHALL be performed modulo MAX_VALUE+1, never by WIDTH-bit overflow; this applies to non-power-of-two MAX_VALUE.

Reset
REQ-031 Rst=1 at an edge SHALL force Count=0, Wrap=0, Sat=0 and Load_Error=0, overriding all other inputs.
REQ-032 Reset mid-operation SHALL discard any in-progress load or step, and counting SHALL resume from 0 on the first edge with Rst=0.

Verification (WIDTH=4, MAX_VALUE=9)
REQ-033 Scenario: Rst=1 for 2 cycles with Enable=1 and Load_Value_Valid=1 -> Count=0 and all flags 0.
REQ-034 Scenario: Mode=0, up, Enable=1 from Count=0 for 10 edges -> Count=1..9 then 0; Wrap=1 only in the cycle Count=0; Terminal_Count=1 while Count=9.
REQ-035 Scenario: load 2, then Mode=1, down, Enable=1 for 4 edges -> Count=1,0,0,0; Sat=0,0,1,1; Terminal_Count=1 at Count=0.
REQ-036 Scenario: Load_Value=4'hC with Load_Value_Valid=1 -> Count=9 and Load_Error=1 for one cycle; then load 4'h5 -> Count=5 and Load_Error=0.
REQ-037 Scenario: Clear, Load_Value_Valid (value 7) and Enable all high at Count=4 -> Count=0; then Load 7 with Enable=1 -> Count=7, not 8.
REQ-038 Scenario: Rst=1 asserted at Count=7 during an up-count -> Count=0 next edge; after release, Count=1 on the first enabled edge.

Source files
------------

// File: rtl/multi_mode_load_counter_if.sv
// Control/status bundle for multi_mode_load_counter.
// The master drives the counter controls and the slave (the counter) returns
// its count and status flags.
interface multi_mode_load_counter_if #(
    parameter int WIDTH = 4
);
    logic             Enable;
    logic             Up_Down;
    logic             Mode;
    logic             Clear;
    logic             Load_Value_Valid;
    logic [WIDTH-1:0] Load_Value;
    logic [WIDTH-1:0] Count;
    logic             Terminal_Count;
    logic             Wrap;
    logic             Sat;
    logic             Load_Error;

    modport master (
        output Enable, Up_Down, Mode, Clear, Load_Value_Valid, Load_Value,
        input  Count, Terminal_Count, Wrap, Sat, Load_Error
    );

    modport slave (
        input  Enable, Up_Down, Mode, Clear, Load_Value_Valid, Load_Value,
        output Count, Terminal_Count, Wrap, Sat, Load_Error
    );
endinterface

// File: rtl/multi_mode_load_counter.sv
// Up/down counter with a range of 0..MAX_VALUE, selectable wrap or saturate
// behaviour at the limits, synchronous clear and range-checked parallel load.
// Per-edge priority: Rst > Clear > load > count step > hold.
module multi_mode_load_counter #(
    parameter int WIDTH     = 4,
    parameter int MAX_VALUE = 2**WIDTH - 1
) (
    input  logic                     Clk,
    input  logic                     Rst,
    multi_mode_load_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             sat_q, sat_d;
    logic             load_err_q, load_err_d;

    // Next-state: limits are tested explicitly so the count wraps modulo
    // MAX_VALUE+1 rather than relying on WIDTH-bit overflow.
    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        sat_d      = 1'b0;
        load_err_d = 1'b0;
        if (bus.Clear) begin
            count_d = '0;
        end else if (bus.Load_Value_Valid) begin
            if (bus.Load_Value > MAX_V) begin
                count_d    = MAX_V;
                load_err_d = 1'b1;
            end else begin
                count_d = bus.Load_Value;
            end
        end else if (bus.Enable) begin
            if (bus.Up_Down) begin
                if (count_q >= MAX_V) begin
                    if (bus.Mode) begin
                        sat_d = 1'b1;
                    end else begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q + ONE;
                end
            end else begin
                if (count_q == '0) begin
                    if (bus.Mode) begin
                        sat_d = 1'b1;
                    end else begin
                        count_d = MAX_V;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q - ONE;
                end
            end
        end
    end

    // State and flag registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            sat_q      <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            sat_q      <= sat_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.Count          = count_q;
    assign bus.Wrap           = wrap_q;
    assign bus.Sat            = sat_q;
    assign bus.Load_Error     = load_err_q;
    assign bus.Terminal_Count = ( bus.Up_Down && (count_q == MAX_V)) ||
                                (!bus.Up_Down && (count_q == '0));

endmodule

// File: tb/tb_multi_mode_load_counter.sv
// Directed bench for multi_mode_load_counter with WIDTH=4, MAX_VALUE=9.
module tb_multi_mode_load_counter;

    logic Clk = 1'b0;
    logic Rst;
    int   checks   = 0;
    int   failures = 0;

    multi_mode_load_counter_if #(.WIDTH(4)) bus ();

    multi_mode_load_counter #(
        .WIDTH     (4),
        .MAX_VALUE (9)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus.slave)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int cnt, input bit wrap,
                             input bit sat, input bit lerr, input bit tc);
        check({tag, ".count"}, 32'(bus.Count), 32'(cnt));
        check({tag, ".wrap"},  32'(bus.Wrap),  32'(wrap));
        check({tag, ".sat"},   32'(bus.Sat),   32'(sat));
        check({tag, ".lerr"},  32'(bus.Load_Error), 32'(lerr));
        check({tag, ".tc"},    32'(bus.Terminal_Count), 32'(tc));
    endtask

    initial begin
        // Reset held two cycles while Enable and a load are requested.
        Rst                  = 1'b1;
        bus.Enable           = 1'b1;
        bus.Up_Down          = 1'b1;
        bus.Mode             = 1'b0;
        bus.Clear            = 1'b0;
        bus.Load_Value_Valid = 1'b1;
        bus.Load_Value       = 4'd5;
        tick();
        check_all("rst1", 0, 0, 0, 0, 0);
        tick();
        check_all("rst2", 0, 0, 0, 0, 0);

        // Wrap-mode up count through the limit.
        Rst                  = 1'b0;
        bus.Load_Value_Valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check_all($sformatf("up%0d", i), i % 10, i == 10, 0, 0, i == 9);
        end

        // Load 2, then saturating down count.
        bus.Load_Value_Valid = 1'b1;
        bus.Load_Value       = 4'd2;
        tick();
        check_all("load2", 2, 0, 0, 0, 0);
        bus.Load_Value_Valid = 1'b0;
        bus.Mode             = 1'b1;
        bus.Up_Down          = 1'b0;
        #1;
        check("tc_dir_change", 32'(bus.Terminal_Count), 32'd0);
        tick(); check_all("dn1", 1, 0, 0, 0, 0);
        tick(); check_all("dn2", 0, 0, 0, 0, 1);
        tick(); check_all("dn3", 0, 0, 1, 0, 1);
        tick(); check_all("dn4", 0, 0, 1, 0, 1);

        // Out-of-range load clamps and flags; next in-range load clears flag.
        bus.Load_Value_Valid = 1'b1;
        bus.Load_Value       = 4'hC;
        tick(); check_all("loadC", 9, 0, 0, 1, 0);
        bus.Load_Value       = 4'h5;
        tick(); check_all("load5", 5, 0, 0, 0, 0);
        bus.Load_Value_Valid = 1'b0;
        bus.Enable           = 1'b0;
        tick(); check_all("hold5", 5, 0, 0, 0, 0);

        // Clear beats load and enable; load beats enable.
        bus.Load_Value_Valid = 1'b1;
        bus.Load_Value       = 4'd4;
        tick(); check_all("load4", 4, 0, 0, 0, 0);
        bus.Clear            = 1'b1;
        bus.Load_Value       = 4'd7;
        bus.Enable           = 1'b1;
        bus.Up_Down          = 1'b1;
        bus.Mode             = 1'b0;
        tick(); check_all("clear", 0, 0, 0, 0, 0);
        bus.Clear            = 1'b0;
        tick(); check_all("load7", 7, 0, 0, 0, 0);
        bus.Load_Value_Valid = 1'b0;
        tick(); check_all("up8", 8, 0, 0, 0, 0);

        // Down wrap from 0 to MAX_VALUE.
        bus.Load_Value_Valid = 1'b1;
        bus.Load_Value       = 4'd0;
        bus.Up_Down          = 1'b0;
        tick(); check_all("load0", 0, 0, 0, 0, 1);
        bus.Load_Value_Valid = 1'b0;
        tick(); check_all("dnwrap", 9, 1, 0, 0, 0);
        tick(); check_all("dn8", 8, 0, 0, 0, 0);

        // Saturate at top, then hold drops Sat.
        bus.Load_Value_Valid = 1'b1;
        bus.Load_Value       = 4'd9;
        bus.Up_Down          = 1'b1;
        bus.Mode             = 1'b1;
        tick(); check_all("load9", 9, 0, 0, 0, 1);
        bus.Load_Value_Valid = 1'b0;
        tick(); check_all("upsat", 9, 0, 1, 0, 1);
        bus.Enable           = 1'b0;
        tick(); check_all("hold9", 9, 0, 0, 0, 1);

        // Reset mid up-count, then resume from 0.
        bus.Load_Value_Valid = 1'b1;
        bus.Load_Value       = 4'd6;
        bus.Enable           = 1'b1;
        bus.Mode             = 1'b0;
        tick(); check_all("load6", 6, 0, 0, 0, 0);
        bus.Load_Value_Valid = 1'b0;
        tick(); check_all("up7", 7, 0, 0, 0, 0);
        Rst = 1'b1;
        tick(); check_all("rstmid", 0, 0, 0, 0, 0);
        Rst = 1'b0;
        tick(); check_all("resume", 1, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
